// File: rtl/operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : operand_fetch                                              |
// | Description : Scoreboard-gated operand fetch stage between decode and    |
// |               issue; reads the register bank and marks rd pending.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module operand_fetch #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int PWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AWIDTH-1:0]      in_rs1,
  input  logic [AWIDTH-1:0]      in_rs2,
  input  logic [AWIDTH-1:0]      in_rd,
  input  logic [PWIDTH-1:0]      in_payload,
  output logic [2*AWIDTH-1:0]    read_addr,
  input  logic [2*DWIDTH-1:0]    read_data,
  input  logic [(2**AWIDTH)-1:0] register_valid,
  output logic [AWIDTH-1:0]      invalidate_register,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DWIDTH-1:0]      out_op1,
  output logic [DWIDTH-1:0]      out_op2,
  output logic [AWIDTH-1:0]      out_rd,
  output logic [PWIDTH-1:0]      out_payload,
  output logic [31:0]            stall_cycles
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [AWIDTH-1:0] c_reg_zero  = '0;
  localparam logic [31:0]       c_stall_max = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [AWIDTH-1:0] r_rs1;
  logic [AWIDTH-1:0] r_rs2;
  logic [AWIDTH-1:0] r_rd;
  logic [PWIDTH-1:0] r_payload;
  logic              r_out_valid;
  logic [DWIDTH-1:0] r_out_op1;
  logic [DWIDTH-1:0] r_out_op2;
  logic [AWIDTH-1:0] r_out_rd;
  logic [PWIDTH-1:0] r_out_payload;
  logic [31:0]       r_stall_cycles;

  logic w_src1_ok;
  logic w_src2_ok;
  logic w_dst_ok;
  logic w_operands_ok;
  logic w_in_ready;
  logic w_accept;
  logic w_issue;

  // rd == 0 is the "no destination" encoding, so it never blocks on the scoreboard.
  assign w_src1_ok     = register_valid[r_rs1];
  assign w_src2_ok     = register_valid[r_rs2];
  assign w_dst_ok      = (r_rd == c_reg_zero) | register_valid[r_rd];
  assign w_operands_ok = w_src1_ok & w_src2_ok & w_dst_ok;

  assign w_in_ready = ~reset & ((r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready));
  assign w_accept   = in_valid & w_in_ready;
  assign w_issue    = (r_state == S_CHECK) & w_operands_ok & ~reset;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_CHECK;
      S_CHECK: if (w_operands_ok) w_state_next = S_READ;
      S_READ:  w_state_next = S_HOLD;
      S_HOLD: begin
        if (out_ready) w_state_next = w_accept ? S_CHECK : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_payload      <= '0;
      r_out_valid    <= 1'b0;
      r_out_op1      <= '0;
      r_out_op2      <= '0;
      r_out_rd       <= '0;
      r_out_payload  <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_rs1     <= in_rs1;
        r_rs2     <= in_rs2;
        r_rd      <= in_rd;
        r_payload <= in_payload;
      end

      if ((r_state == S_CHECK) && !w_operands_ok && (r_stall_cycles != c_stall_max)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end

      // Bank data here reflects read_addr from the CHECK cycle, i.e. before rd's invalidation lands.
      if (r_state == S_READ) begin
        r_out_valid   <= 1'b1;
        r_out_op1     <= read_data[DWIDTH-1:0];
        r_out_op2     <= read_data[2*DWIDTH-1:DWIDTH];
        r_out_rd      <= r_rd;
        r_out_payload <= r_payload;
      end else if ((r_state == S_HOLD) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready            = w_in_ready;
  assign read_addr           = {r_rs2, r_rs1};
  assign invalidate_register = w_issue ? r_rd : c_reg_zero;
  assign out_valid           = r_out_valid;
  assign out_op1             = r_out_op1;
  assign out_op2             = r_out_op2;
  assign out_rd              = r_out_rd;
  assign out_payload         = r_out_payload;
  assign stall_cycles        = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_operand_fetch                                           |
// | Description : Directed self-checking bench for operand_fetch with a      |
// |               one-cycle-latency register bank model.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_payload = '0;
  logic [9:0]  read_addr;
  logic [63:0] read_data;
  logic [31:0] register_valid = '1;
  logic [4:0]  invalidate_register;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic [31:0] out_payload;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  logic [31:0] regs [0:31];
  logic [31:0] bank_rd0 = '0;
  logic [31:0] bank_rd1 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bank_rd0 <= (read_addr[4:0] == 5'd0) ? 32'd0 : regs[read_addr[4:0]];
    bank_rd1 <= (read_addr[9:5] == 5'd0) ? 32'd0 : regs[read_addr[9:5]];
  end
  assign read_data = {bank_rd1, bank_rd0};

  operand_fetch #(.DWIDTH(32), .AWIDTH(5), .PWIDTH(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_rs1              (in_rs1),
    .in_rs2              (in_rs2),
    .in_rd               (in_rd),
    .in_payload          (in_payload),
    .read_addr           (read_addr),
    .read_data           (read_data),
    .register_valid      (register_valid),
    .invalidate_register (invalidate_register),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_op1             (out_op1),
    .out_op2             (out_op2),
    .out_rd              (out_rd),
    .out_payload         (out_payload),
    .stall_cycles        (stall_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for one cycle; caller ensures in_ready is high.
  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] payload);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_payload = payload;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_op1 !== 32'd0 || out_op2 !== 32'd0 || out_rd !== 5'd0 || out_payload !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: valid=%b op1=%h op2=%h rd=%0d pl=%h required all zero", out_valid, out_op1, out_op2, out_rd, out_payload);
    end
    total++;
    if (invalidate_register !== 5'd0 || stall_cycles !== 32'd0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: inv=%0d stall=%0d in_ready=%b required 0/0/0", invalidate_register, stall_cycles, in_ready);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || read_addr !== 10'd0) begin
      bad++; $display("FAIL reset_idle: in_ready=%b read_addr=%h required 1/000", in_ready, read_addr);
    end
    tick();
  endtask

  task automatic test_basic();
    send(5'd3, 5'd4, 5'd5, 32'h0000ABCD);
    @(negedge clk);
    total++;
    if (invalidate_register !== 5'd5 || read_addr !== {5'd4, 5'd3}) begin
      bad++; $display("FAIL basic_check: inv=%0d raddr=%h required 5/%h", invalidate_register, read_addr, {5'd4, 5'd3});
    end
    tick();
    @(negedge clk);
    total++;
    if (invalidate_register !== 5'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_read: inv=%0d out_valid=%b required 0/0", invalidate_register, out_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h11 || out_op2 !== 32'h22 || out_rd !== 5'd5 || out_payload !== 32'hABCD) begin
      bad++; $display("FAIL basic_out: v=%b op1=%h op2=%h rd=%0d pl=%h required 1/11/22/5/abcd", out_valid, out_op1, out_op2, out_rd, out_payload);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_hold_ready: in_ready=%b required 0", in_ready);
    end
    drain();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_raw_stall();
    register_valid[3] = 1'b0;
    send(5'd3, 5'd4, 5'd8, 32'h00000008);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (invalidate_register !== 5'd0) begin
        bad++; $display("FAIL raw_stall_inv[%0d]: inv=%0d required 0", i, invalidate_register);
      end
      tick();
    end
    regs[3] = 32'h77;
    register_valid[3] = 1'b1;
    @(negedge clk);
    total++;
    if (invalidate_register !== 5'd8 || stall_cycles !== 32'd4) begin
      bad++; $display("FAIL raw_release: inv=%0d stall=%0d required 8/4", invalidate_register, stall_cycles);
    end
    tick(); tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h77 || out_op2 !== 32'h22) begin
      bad++; $display("FAIL raw_out: v=%b op1=%h op2=%h required 1/77/22", out_valid, out_op1, out_op2);
    end
    drain();
  endtask

  task automatic test_waw_stall();
    register_valid[7] = 1'b0;
    send(5'd1, 5'd2, 5'd7, 32'h00000007);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (invalidate_register !== 5'd0) begin
        bad++; $display("FAIL waw_stall_inv[%0d]: inv=%0d required 0", i, invalidate_register);
      end
      tick();
    end
    register_valid[7] = 1'b1;
    @(negedge clk);
    total++;
    if (invalidate_register !== 5'd7 || stall_cycles !== 32'd6) begin
      bad++; $display("FAIL waw_release: inv=%0d stall=%0d required 7/6", invalidate_register, stall_cycles);
    end
    tick(); tick();
    @(negedge clk);
    total++;
    if (out_op1 !== 32'h101 || out_op2 !== 32'h202 || out_rd !== 5'd7) begin
      bad++; $display("FAIL waw_out: op1=%h op2=%h rd=%0d required 101/202/7", out_op1, out_op2, out_rd);
    end
    drain();
  endtask

  task automatic test_same_reg();
    int inv_count = 0;
    send(5'd6, 5'd0, 5'd6, 32'h00000006);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (invalidate_register === 5'd6) inv_count++;
      tick();
      // Scoreboard reacts to the invalidation; the fetched value must predate it.
      if (inv_count > 0) register_valid[6] = 1'b0;
    end
    @(negedge clk);
    total++;
    if (inv_count !== 1) begin
      bad++; $display("FAIL same_reg_inv_count: count=%0d required 1", inv_count);
    end
    total++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h55 || out_op2 !== 32'd0 || out_rd !== 5'd6) begin
      bad++; $display("FAIL same_reg_out: v=%b op1=%h op2=%h rd=%0d required 1/55/0/6", out_valid, out_op1, out_op2, out_rd);
    end
    register_valid[6] = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    send(5'd3, 5'd4, 5'd9, 32'h00001111);
    tick(); tick();
    in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd10; in_payload = 32'h00002222;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_op1 !== 32'h77 || out_op2 !== 32'h22 || out_rd !== 5'd9 ||
          out_payload !== 32'h1111 || in_ready !== 1'b0) begin
        bad++; $display("FAIL b2b_hold[%0d]: v=%b op1=%h op2=%h rd=%0d pl=%h in_ready=%b required 1/77/22/9/1111/0",
                        i, out_valid, out_op1, out_op2, out_rd, out_payload, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_accept_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || invalidate_register !== 5'd10) begin
      bad++; $display("FAIL b2b_next_check: out_valid=%b inv=%0d required 0/10", out_valid, invalidate_register);
    end
    tick(); tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h101 || out_op2 !== 32'h202 || out_payload !== 32'h2222) begin
      bad++; $display("FAIL b2b_second_out: v=%b op1=%h op2=%h pl=%h required 1/101/202/2222", out_valid, out_op1, out_op2, out_payload);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    register_valid[3] = 1'b0;
    send(5'd3, 5'd4, 5'd11, 32'h0000000B);
    tick();
    reset = 1'b1;
    register_valid[3] = 1'b1;
    @(negedge clk);
    total++;
    if (invalidate_register !== 5'd0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_check_during: inv=%0d in_ready=%b required 0/0", invalidate_register, in_ready);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || invalidate_register !== 5'd0 || stall_cycles !== 32'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_check_after: v=%b inv=%0d stall=%0d in_ready=%b required 0/0/0/1", out_valid, invalidate_register, stall_cycles, in_ready);
    end
    send(5'd1, 5'd2, 5'd12, 32'h00003333);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_payload !== 32'd0 || invalidate_register !== 5'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_hold_after: v=%b pl=%h inv=%0d in_ready=%b required 0/0/0/1", out_valid, out_payload, invalidate_register, in_ready);
    end
    send(5'd3, 5'd4, 5'd13, 32'h00004444);
    @(negedge clk);
    total++;
    if (invalidate_register !== 5'd13) begin
      bad++; $display("FAIL rst_recover_inv: inv=%0d required 13", invalidate_register);
    end
    tick(); tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h77 || out_op2 !== 32'h22 || out_payload !== 32'h4444) begin
      bad++; $display("FAIL rst_recover_out: v=%b op1=%h op2=%h pl=%h required 1/77/22/4444", out_valid, out_op1, out_op2, out_payload);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1] = 32'h101;
    regs[2] = 32'h202;
    regs[3] = 32'h11;
    regs[4] = 32'h22;
    regs[6] = 32'h55;
    #1;
    test_reset();
    test_basic();
    test_raw_stall();
    test_waw_stall();
    test_same_reg();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
